// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with a shift-add multiplier, an accumulator and valid/ready handshakes.
// Define ALU_SAT_EN to saturate ADD, SUB and ACC instead of wrapping.
`timescale 1ns/1ps
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           sel,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 greater,
   output logic                 lesser,
   output logic                 equal,
   output logic                 zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int RW    = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_CMP = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_MUL = 3'b110,
      OP_ACC = 3'b111
   } op_t;

   state_t             state;
   logic [WIDTH-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [RW-1:0]      mcand;
   logic [WIDTH-1:0]   mplier;
   logic [RW-1:0]      prod;

   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_s;
   logic [WIDTH:0]     acc_s;
   logic [WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]   op_res;
   logic               op_carry;
   logic [RW-1:0]      prod_nxt;
   logic               accept;

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      add_s = {1'b0, a} + {1'b0, b};
      sub_s = {1'b0, a} - {1'b0, b};
      acc_s = {1'b0, acc} + {1'b0, a};
`ifdef ALU_SAT_EN
      acc_nxt = acc_s[WIDTH] ? '1 : acc_s[WIDTH-1:0];
`else
      acc_nxt = acc_s[WIDTH-1:0];
`endif
      op_res   = '0;
      op_carry = 1'b0;
      case (op_t'(sel))
         OP_AND: op_res = a & b;
         OP_ADD: begin
            op_carry = add_s[WIDTH];
`ifdef ALU_SAT_EN
            op_res = add_s[WIDTH] ? '1 : add_s[WIDTH-1:0];
`else
            op_res = add_s[WIDTH-1:0];
`endif
         end
         OP_SUB: begin
            // bit WIDTH of the extended difference is the borrow, i.e. a < b
            op_carry = sub_s[WIDTH];
`ifdef ALU_SAT_EN
            op_res = sub_s[WIDTH] ? '0 : sub_s[WIDTH-1:0];
`else
            op_res = sub_s[WIDTH-1:0];
`endif
         end
         OP_CMP: op_res = '0;
         OP_OR:  op_res = a | b;
         OP_XOR: op_res = a ^ b;
         OP_ACC: begin
            op_res   = acc_nxt;
            op_carry = acc_s[WIDTH];
         end
         default: op_res = '0;
      endcase
      prod_nxt = mplier[0] ? (prod + mcand) : prod;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         greater   <= 1'b0;
         lesser    <= 1'b0;
         equal     <= 1'b0;
         zero      <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
      end else begin
         case (state)
            BUSY: begin
               prod   <= prod_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= prod_nxt;
                  zero      <= (prod_nxt == '0);
               end
            end
            DONE: begin
               if (out_ready && !in_valid) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase

         // accept only happens from IDLE or DONE, so it never collides with the BUSY branch
         if (accept) begin
            greater <= (a > b);
            lesser  <= (a < b);
            equal   <= (a == b);
            if (op_t'(sel) == OP_MUL) begin
               state     <= BUSY;
               out_valid <= 1'b0;
               carry     <= 1'b0;
               mcand     <= {{WIDTH{1'b0}}, a};
               mplier    <= b;
               prod      <= '0;
               cnt       <= CNT_W'(WIDTH);
            end else begin
               state     <= DONE;
               out_valid <= 1'b1;
               result    <= {{WIDTH{1'b0}}, op_res};
               carry     <= op_carry;
               zero      <= (op_res == '0);
               if (op_t'(sel) == OP_ACC)
                  acc <= acc_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=4; honours ALU_SAT_EN for expected values.
`timescale 1ns/1ps
module tb_alu_seq;

`ifdef ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam logic [2:0] S_AND = 3'b000, S_ADD = 3'b001, S_SUB = 3'b010, S_CMP = 3'b011,
                          S_OR  = 3'b100, S_XOR = 3'b101, S_MUL = 3'b110, S_ACC = 3'b111;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] sel;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry, greater, lesser, equal, zero;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carry(carry), .greater(greater), .lesser(lesser), .equal(equal), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // full output record: result, carry, {greater,lesser,equal}, zero, out_valid
   task automatic check_out(input string tag, input logic [7:0] r, input logic c,
                            input logic [2:0] gle, input logic z);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".result"}, 32'(result), 32'(r));
      check({tag, ".carry"}, 32'(carry), 32'(c));
      check({tag, ".gle"}, 32'({greater, lesser, equal}), 32'(gle));
      check({tag, ".zero"}, 32'(zero), 32'(z));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] s, input logic [3:0] aa, input logic [3:0] bb);
      sel = s; a = aa; b = bb; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   logic [2:0] tsel [8] = '{S_ADD, S_XOR, S_CMP, S_ADD, S_XOR, S_CMP, S_ADD, S_XOR};
   logic [3:0] ta   [8] = '{4'd3, 4'd10, 4'd6, 4'd15, 4'd12, 4'd2, 4'd8, 4'd9};
   logic [3:0] tb   [8] = '{4'd4, 4'd5, 4'd6, 4'd1, 4'd12, 4'd9, 4'd8, 4'd3};
   logic [3:0] tres [8] = '{4'd7, 4'd15, 4'd0, SAT ? 4'd15 : 4'd0, 4'd0, 4'd0,
                            SAT ? 4'd15 : 4'd0, 4'd10};
   logic       tc   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [2:0] tgle [8] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b100};

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = '0; a = '0; b = '0;
      step(); step();
      rst = 1'b0;
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.result", 32'(result), 32'd0);
      check("rst.flags", 32'({carry, greater, lesser, equal, zero}), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);

      issue(S_ADD, 4'b1101, 4'b1001);
      check_out("add", SAT ? 8'h0F : 8'h06, 1'b1, 3'b100, 1'b0);

      issue(S_SUB, 4'b0100, 4'b1011);
      check_out("sub_borrow", SAT ? 8'h00 : 8'h09, 1'b1, 3'b010, SAT);

      issue(S_SUB, 4'b1000, 4'b1000);
      check_out("sub_eq", 8'h00, 1'b0, 3'b001, 1'b1);

      issue(S_OR, 4'b0101, 4'b1000);
      check_out("or", 8'h0D, 1'b0, 3'b010, 1'b0);

      issue(S_ACC, 4'd3, 4'd0);
      check_out("acc_pre", 8'h03, 1'b0, 3'b100, 1'b0);
      step();
      check("idle.valid", 32'(out_valid), 32'd0);

      // MUL 13*12; a held but ignored request during BUSY must not disturb it
      issue(S_MUL, 4'b1101, 4'b1100);
      sel = S_ADD; a = 4'd1; b = 4'd1; in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("mul.busy%0d.in_ready", i), 32'(in_ready), 32'd0);
         check($sformatf("mul.busy%0d.valid", i), 32'(out_valid), 32'd0);
         if (i == 4) in_valid = 1'b0;
         step();
      end
      check_out("mul", 8'h9C, 1'b0, 3'b100, 1'b0);
      step();

      issue(S_MUL, 4'd0, 4'd5);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("mul0.busy%0d.valid", i), 32'(out_valid), 32'd0);
         step();
      end
      check_out("mul0", 8'h00, 1'b0, 3'b010, 1'b1);
      step();

      // reset in the second cycle of a multiply
      issue(S_MUL, 4'b1101, 4'b1100);
      step();
      rst = 1'b1;
      step();
      check("mul_abort.valid", 32'(out_valid), 32'd0);
      check("mul_abort.in_ready", 32'(in_ready), 32'd1);
      check("mul_abort.result", 32'(result), 32'd0);
      sel = S_ADD; a = 4'd2; b = 4'd3; in_valid = 1'b1;
      step();
      check("rst_prio.valid", 32'(out_valid), 32'd0);
      rst = 1'b0; in_valid = 1'b0;

      // backpressure with a pending request held by the requester
      out_ready = 1'b0;
      issue(S_AND, 4'b0011, 4'b1100);
      sel = S_XOR; a = 4'b0101; b = 4'b0011; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_out($sformatf("bp%0d", i), 8'h00, 1'b0, 3'b010, 1'b1);
         check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp.release.in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check_out("bp.next", 8'h06, 1'b0, 3'b100, 1'b0);

      // accumulator starts from zero after the abort reset
      issue(S_ACC, 4'b0111, 4'd0);
      check_out("acc1", 8'd7, 1'b0, 3'b100, 1'b0);
      issue(S_ACC, 4'b0111, 4'd0);
      check_out("acc2", 8'd14, 1'b0, 3'b100, 1'b0);
      issue(S_ACC, 4'b0111, 4'd0);
      check_out("acc3", SAT ? 8'h0F : 8'h05, 1'b1, 3'b100, 1'b0);
      issue(S_ADD, 4'd1, 4'd1);
      check_out("add_mid", 8'd2, 1'b0, 3'b001, 1'b0);
      issue(S_ACC, 4'd1, 4'd2);
      check_out("acc4", SAT ? 8'h0F : 8'h06, SAT, 3'b010, 1'b0);

      // throughput: one op per cycle with in_valid and out_ready held high
      for (int i = 0; i < 8; i++) begin
         sel = tsel[i]; a = ta[i]; b = tb[i]; in_valid = 1'b1;
         step();
         check_out($sformatf("tp%0d", i), {4'd0, tres[i]}, tc[i], tgle[i], tres[i] == 4'd0);
      end
      in_valid = 1'b0;
      step();
      check("tp.idle", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential successor to the team's 4-bit combinational ALU (add/subtract, compare, AND).
- Widens the datapath to WIDTH bits and extends the opcode to 3 bits.
- Adds a multi-cycle shift-add multiplier and an internal accumulator.
- Wraps every operation in a valid/ready handshake on input and output, so it drops into streaming datapaths with backpressure.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width; derived, not overridden.

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  operation request valid.
in_ready  output  1  block can accept a request this cycle.
sel  input  3  opcode: 000 AND, 001 ADD, 010 SUB, 011 CMP, 100 OR, 101 XOR, 110 MUL, 111 ACC.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts result this cycle.
result  output  2*WIDTH  result; non-MUL ops are zero-extended.
carry  output  1  ADD/ACC carry-out; SUB borrow (1 when a<b); otherwise 0.
greater  output  1  captured a > b, unsigned.
lesser  output  1  captured a < b, unsigned.
equal  output  1  captured a == b.
zero  output  1  result == 0.

Behaviour:
Interface and reset:
- One clock (clk); reset rst is synchronous and active-high.
- Reset state: state IDLE, out_valid 0, result 0, carry 0, greater 0, lesser 0, equal 0, zero 0, accumulator 0, counter 0.

States:
- IDLE: no result held.
- BUSY: multiply in progress.
- DONE: result held.

Handshake:
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and does not depend on in_valid.
- A request is accepted when in_valid && in_ready.
- out_valid = (state==DONE).
- Outputs hold stable while out_valid && !out_ready.

Single-cycle ops (all except MUL):
- Accept moves to DONE next cycle, so latency is 1.
- Back-to-back accepts with out_ready=1 give throughput 1 op/cycle (DONE→DONE).

MUL:
- Accept loads multiplicand/multiplier, clears the product and sets the counter to WIDTH.
- BUSY iterates one shift-add per cycle for WIDTH cycles, then goes to DONE.
- out_valid is asserted WIDTH+1 cycles after accept.
- in_ready is 0 throughout BUSY.

Arithmetic (W = WIDTH; results mod 2^W unless noted):
- AND/OR/XOR: bitwise; carry 0.
- ADD: result[W-1:0] = a+b; carry = bit W of the sum.
- SUB: result[W-1:0] = a-b; carry = (a<b).
- CMP: result 0; flags only; carry 0.
- MUL: full 2W-bit unsigned product; carry 0.
- ACC: acc_next = acc + a (b ignored); result = acc_next; carry = overflow; the accumulator register updates on accept.

Flags:
- greater/lesser/equal are computed from the captured a,b for every opcode and registered with the result.
- Exactly one of the three is 1 while out_valid.

Other DONE exits:
- DONE with out_ready and no new accept returns to IDLE.

Boundary conditions:
- rst during BUSY aborts the multiply: next cycle IDLE, out_valid 0, accumulator cleared.
- rst has priority over any simultaneous accept.
- in_valid while in_ready=0 is ignored. The requester must hold the request; the block does not latch it.
- ACC wraps at 2^W and sets carry.
- MUL with a or b = 0 still takes the full WIDTH+1 latency.
- The accumulator is unaffected by other opcodes.

Optional Feature:
ALU_SAT_EN
- Defined:
  - ADD saturates result[W-1:0] to all-ones on carry.
  - SUB saturates to 0 on borrow.
  - ACC saturates the accumulator at all-ones.
  - carry still reports the raw overflow/borrow.
- Undefined: all ops wrap modulo 2^W as above.

Test Plan:
- ADD a=1101 b=1001, out_ready=1 → next cycle out_valid=1, result=0x06, carry=1, greater=1; with ALU_SAT_EN result=0x0F.
- SUB a=0100 b=1011 → result=0x09, carry=1, lesser=1; with ALU_SAT_EN result=0x00. SUB 1000-1000 → result 0, zero=1, equal=1.
- MUL a=1101 b=1100 → in_ready=0 for 4 cycles, out_valid 5 cycles after accept, result=0x9C. Assert rst at cycle 2 of a second MUL → IDLE, out_valid=0 next cycle.
- Backpressure: AND a=0011 b=1100 with out_ready=0 for 3 cycles → result=0, zero=1 held stable, in_ready=0. out_ready=1 → in_ready=1 same cycle and the next op is accepted with no bubble.
- ACC stream a=0111, 0111, 0111 (out_ready=1) → results 7, 14 carry 0, then 5 carry 1; with ALU_SAT_EN third result=0x0F.
- Throughput: 8 consecutive ADD/XOR/CMP ops with in_valid=out_ready=1 → one result per cycle, ordered; CMP returns result 0 with correct flags.
